// File: rtl/seg_pkg.sv
// Shared types for the seven-segment display scheduler.
// State encoding, blink period and the 1 ms prescaler length.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam int unsigned BLINK_MS = 250;

  function automatic int unsigned ms_cycles(input int unsigned mhz);
    return mhz * 1000;
  endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i
// at or above start_i, wrapping. Ports: valid_i, start_i -> found_o, idx_o.
module seg_rr_pick #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int k;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start_i) + i) % N;
      if (!found_o && valid_i[k]) begin
        found_o = 1'b1;
        idx_o   = W'(k);
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin scheduler sharing one 7-seg driver among SOURCES requesters,
// with dwell timer, next pulse, hold and urgent preemption.
// Ports: clk_i, rst_ni, src_valid_i/urgent_i/data_i/dots_i, next_i, hold_i
// -> data_o, dots_o, sel_o, sel_valid_o.
// Option: SEG_SCHED_SRCDOT_EN replaces dots_o with a 2 Hz source indicator.
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter  int CLOCKFREQ = 100,
  parameter  int DIGITS    = 4,
  parameter  int SOURCES   = 4,
  parameter  int DWELL_MS  = 1000,
  localparam int W         = $clog2(SOURCES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [SOURCES-1:0]          src_valid_i,
  input  logic [SOURCES-1:0]          src_urgent_i,
  input  logic [SOURCES*DIGITS*4-1:0] src_data_i,
  input  logic [SOURCES*DIGITS-1:0]   src_dots_i,
  input  logic                        next_i,
  input  logic                        hold_i,
  output logic [DIGITS*4-1:0]         data_o,
  output logic [DIGITS-1:0]           dots_o,
  output logic [W-1:0]                sel_o,
  output logic                        sel_valid_o
);

  localparam int MS  = int'(ms_cycles(CLOCKFREQ));
  localparam int PW  = (MS > 1) ? $clog2(MS) : 1;
  localparam int DWW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;

  state_e              state_q, state_d;
  logic [W-1:0]        sel_q, sel_d;
  logic [DIGITS*4-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dots_q, dots_d;
  logic                vld_q, vld_d;
  logic [PW-1:0]       presc_q;
  logic [DWW-1:0]      dwell_q, dwell_d;
  logic                ms_tick;

  logic [W-1:0]        start;
  logic                pick_found, urg_found;
  logic [W-1:0]        pick_idx, urg_idx;
  logic [SOURCES-1:0]  urg_vec;

  function automatic logic [DIGITS*4-1:0] data_of(input logic [W-1:0] s);
    return src_data_i[int'(s)*DIGITS*4 +: DIGITS*4];
  endfunction

  function automatic logic [DIGITS-1:0] dots_of(input logic [W-1:0] s);
    return src_dots_i[int'(s)*DIGITS +: DIGITS];
  endfunction

  assign ms_tick = (presc_q == PW'(MS - 1));

  // Current selection is searched last.
  assign start = (sel_q == W'(SOURCES - 1)) ? '0 : sel_q + 1'b1;

  // Lowest-index urgent source other than the one on display.
  always_comb begin
    urg_vec = src_urgent_i & src_valid_i;
    urg_vec[sel_q] = 1'b0;
  end

  seg_rr_pick #(.N(SOURCES)) u_scan (
    .valid_i (src_valid_i),
    .start_i (start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  seg_rr_pick #(.N(SOURCES)) u_urg (
    .valid_i (urg_vec),
    .start_i ('0),
    .found_o (urg_found),
    .idx_o   (urg_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    dots_d  = dots_q;
    vld_d   = vld_q;
    dwell_d = dwell_q;
    unique case (state_q)
      IDLE: begin
        data_d = '0;
        dots_d = '0;
        vld_d  = 1'b0;
        if (|src_valid_i) state_d = SCAN;
      end
      SCAN: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          data_d  = data_of(pick_idx);
          dots_d  = dots_of(pick_idx);
          vld_d   = 1'b1;
          dwell_d = '0;
          state_d = SHOW;
        end else begin
          data_d  = '0;
          dots_d  = '0;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SHOW: begin
        data_d = data_of(sel_q);
        dots_d = dots_of(sel_q);
        if (urg_found) begin
          sel_d   = urg_idx;
          data_d  = data_of(urg_idx);
          dots_d  = dots_of(urg_idx);
          dwell_d = '0;
        end else if (!src_valid_i[sel_q]) begin
          state_d = SCAN;
        end else if (next_i) begin
          state_d = SCAN;
        end else if (ms_tick && !hold_i) begin
          if (dwell_q == DWW'(DWELL_MS - 1)) begin
            state_d = SCAN;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= W'(SOURCES - 1);
      data_q  <= '0;
      vld_q   <= 1'b0;
      presc_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      presc_q <= ms_tick ? '0 : presc_q + 1'b1;
      dwell_q <= dwell_d;
    end
  end

`ifdef SEG_SCHED_SRCDOT_EN
  logic [7:0]        blink_q, blink_d;
  logic              ph_q, ph_d;
  logic              sel_load;
  logic [DIGITS-1:0] ind_d;
  logic              unused_dots;

  assign unused_dots = ^{src_dots_i, dots_d};

  assign sel_load = (state_q == SCAN && pick_found) ||
                    (state_q == SHOW && urg_found);

  // Phase restarts lit on every new selection.
  always_comb begin
    blink_d = blink_q;
    ph_d    = ph_q;
    if (state_q == SHOW && ms_tick) begin
      if (blink_q == 8'(BLINK_MS - 1)) begin
        blink_d = '0;
        ph_d    = ~ph_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    if (sel_load) begin
      blink_d = '0;
      ph_d    = 1'b1;
    end
    ind_d = '0;
    if (vld_d) ind_d[int'(sel_d) % DIGITS] = ph_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_q <= '0;
      ph_q    <= 1'b0;
      dots_q  <= '0;
    end else begin
      blink_q <= blink_d;
      ph_q    <= ph_d;
      dots_q  <= ind_d;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dots_q <= '0;
    else         dots_q <= dots_d;
  end
`endif

  assign data_o      = data_q;
  assign dots_o      = dots_q;
  assign sel_o       = sel_q;
  assign sel_valid_o = vld_q;

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Shares the 4-digit seven-segment display driver between up to SOURCES requesters, e.g. CPU debug views such as PC, accumulator, index registers and status.
- Rotates round-robin between valid sources with a programmable dwell time.
- Supports a manual "next" pulse, a hold, and urgent preemption.
- Sits directly upstream of the display driver: its data_o/dots_o drive the driver's data_i/dots_i.

Parameters:
- CLOCKFREQ, 100, clk_i frequency in MHz; sets the 1 ms tick prescaler (CLOCKFREQ*1000 cycles).
- DIGITS, 4, digits per display page.
- SOURCES, 4, number of requesters; must be >= 2.
- DWELL_MS, 1000, milliseconds each source is shown before auto-advance; must be >= 1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- src_valid_i  in  SOURCES  source k has displayable data
- src_urgent_i  in  SOURCES  source k requests immediate preemption (ignored unless src_valid_i[k])
- src_data_i  in  SOURCES*DIGITS*4  hex nibbles; source k occupies bits [k*DIGITS*4 +: DIGITS*4]
- src_dots_i  in  SOURCES*DIGITS  decimal points; source k occupies bits [k*DIGITS +: DIGITS]
- next_i  in  1  single-cycle pulse: advance to next valid source
- hold_i  in  1  level: freeze dwell timer
- data_o  out  DIGITS*4  nibbles to display driver
- dots_o  out  DIGITS  dots to display driver
- sel_o  out  clog2(SOURCES)  index of displayed source
- sel_valid_o  out  1  data_o/dots_o belong to sel_o

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low, on rst_ni.
- Reset values: state=IDLE, sel_o=SOURCES-1 (so the first scan starts at 0), sel_valid_o=0, data_o=0, dots_o=0, prescaler=0, dwell=0.
- Registers: all outputs are registered.
- Tick: a prescaler counts 0..CLOCKFREQ*1000-1 and wraps, producing a one-cycle ms_tick at wrap. It runs freely in every state and is unaffected by hold_i.
- IDLE:
  - Outputs sel_valid_o=0, data_o=0, dots_o=0.
  - If any src_valid_i bit is set -> SCAN next cycle.
- SCAN (exactly one cycle):
  - Combinationally pick the first k with src_valid_i[k], searching from (sel_o+1) mod SOURCES upward with wrap; the current sel_o is tested last.
  - If found: sel_o<=k, data_o/dots_o<=source k slices, sel_valid_o<=1, dwell<=0 -> SHOW.
  - If none found: sel_valid_o<=0, data_o<=0, dots_o<=0 -> IDLE.
- SHOW:
  - data_o/dots_o reload from source sel_o every cycle (live, 1-cycle latency).
  - dwell increments on ms_tick when hold_i=0.
- SHOW exit priority, highest first, evaluated every cycle:
  1. Urgent: lowest k with src_urgent_i[k]&src_valid_i[k] and k!=sel_o. Load sel_o<=k and data directly, dwell<=0, stay in SHOW. Urgent on the current sel_o has no effect.
  2. !src_valid_i[sel_o] -> SCAN.
  3. next_i -> SCAN.
  4. ms_tick & !hold_i & dwell==DWELL_MS-1 -> SCAN, dwell<=0.
- hold_i blocks only rule 4.
- next_i in IDLE or SCAN is ignored.
- Latency: src_valid_i high sampled at edge N in IDLE -> SCAN after edge N -> sel_valid_o=1 and data valid after edge N+1.
- Single valid source: on dwell expiry, SCAN reselects the same source. Output stays continuous except that dwell restarts.
- Reset mid-operation: asynchronous return to reset values; no partial update is held.
- Wrap: the sel_o+1 search wraps from SOURCES-1 to 0.

Optional Feature:
- Macro: SEG_SCHED_SRCDOT_EN.
- Defined:
  - dots_o is overridden by a source indicator: dot[sel_o mod DIGITS] blinks at 2 Hz (toggles every 250 ms ticks, phase reset on each selection); all other dots are 0.
  - src_dots_i is ignored.
  - IDLE still drives dots_o=0.
- Undefined: dots_o follows src_dots_i of the selected source; no blink counter is synthesized.

Decomposition:
- Package seg_pkg: state encoding (IDLE, SCAN, SHOW), and the ms prescaler constant function of CLOCKFREQ.
- Sub-module seg_rr_pick (combinational):
  - Inputs: valid vector, start index.
  - Outputs: found, index.
  - Reused later for other round-robin arbiters.

Test Plan:
All scenarios use CLOCKFREQ=1 (1000 cycles/ms), DWELL_MS=2, SOURCES=4.
1. Reset then src_valid_i=4'b0101, data0=16'h1234 -> after 2 edges sel_o=0, data_o=1234, sel_valid_o=1; after 2 ms ticks sel_o=2; next expiry sel_o=0.
2. SHOW on sel 0, pulse next_i for 1 cycle with valid=4'b1001 -> SCAN, then sel_o=3 with data3 on the following edge; dwell restarts from 0.
3. SHOW on sel 2, hold_i=1 for 5 ms -> sel_o stays 2. Pulse next_i while holding -> sel_o advances. Deassert hold -> dwell expires normally.
4. SHOW on sel 1, src_urgent_i=4'b1010 and valid=4'b1111 -> sel_o=3 one edge later; urgent on sel 1 alone -> no change. Urgent+next in the same cycle -> urgent wins.
5. SHOW on sel 2, drop src_valid_i to 0 -> SCAN -> IDLE, data_o=0, sel_valid_o=0. Assert rst_ni=0 mid-SHOW -> sel_o=3 and outputs 0 immediately, without a clock edge.
6. With SEG_SCHED_SRCDOT_EN defined, sel_o=1 -> dots_o toggles between 4'b0010 and 4'b0000 every 250 ms ticks; src_dots_i=4'hF is ignored.
